// File: rtl/bscan_virtex_sim_pkg.sv
// Shared TAP definitions for the simulation model of the Virtex boundary-scan block.
// Holds the 1149.1 state enumeration and the IR reset/capture constants.
package bscan_virtex_sim_pkg;

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET,
    RUN_TEST_IDLE,
    SELECT_DR_SCAN,
    CAPTURE_DR,
    SHIFT_DR,
    EXIT1_DR,
    PAUSE_DR,
    EXIT2_DR,
    UPDATE_DR,
    SELECT_IR_SCAN,
    CAPTURE_IR,
    SHIFT_IR,
    EXIT1_IR,
    PAUSE_IR,
    EXIT2_IR,
    UPDATE_IR
  } tap_state_t;

  // Constants are stored at the widest supported IR and sliced down by the user.
  localparam int                      IR_MAX_WIDTH   = 32;
  localparam logic [IR_MAX_WIDTH-1:0] IR_BYPASS_ALL  = '1;
  localparam logic [IR_MAX_WIDTH-1:0] IR_CAPTURE_ALL = 32'h0000_0001;

  // States in which a selected user chain receives DRCK pulses.
  function automatic logic drck_window(input tap_state_t s);
    return (s == CAPTURE_DR) || (s == SHIFT_DR);
  endfunction

endpackage

// File: rtl/bscan_tap_fsm.sv
// IEEE 1149.1 TAP controller: 16-state FSM advanced on rising TCK by TMS.
// SHIFT/UPDATE/RESET flags are registered alongside the state so they never glitch.
module bscan_tap_fsm
  import bscan_virtex_sim_pkg::*;
(
  input  logic       tck,
  input  logic       trst,
  input  logic       tms,
  output tap_state_t state,
  output logic       shift_dr,
  output logic       update_dr,
  output logic       test_logic_reset
);

  tap_state_t state_next;

  // NOTE: sequential state is written with non-blocking assignments so every flop
  // samples the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      state            <= TEST_LOGIC_RESET;
      shift_dr         <= 1'b0;
      update_dr        <= 1'b0;
      test_logic_reset <= 1'b1;
    end else begin
      state            <= state_next;
      shift_dr         <= (state_next == SHIFT_DR);
      update_dr        <= (state_next == UPDATE_DR);
      test_logic_reset <= (state_next == TEST_LOGIC_RESET);
    end
  end

  // NOTE: state_next gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      TEST_LOGIC_RESET: state_next = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    state_next = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_DR_SCAN:   state_next = tms ? SELECT_IR_SCAN   : CAPTURE_DR;
      CAPTURE_DR:       state_next = tms ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         state_next = tms ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         state_next = tms ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         state_next = tms ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         state_next = tms ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        state_next = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_IR_SCAN:   state_next = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       state_next = tms ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         state_next = tms ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         state_next = tms ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         state_next = tms ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         state_next = tms ? UPDATE_IR        : SHIFT_IR;
      UPDATE_IR:        state_next = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      default:          state_next = TEST_LOGIC_RESET;
    endcase
  end

endmodule

// File: rtl/bscan_virtex_sim.sv
// Behavioural stand-in for the Virtex BSCAN primitive: TAP, IR, bypass, TDO mux
// and DRCK gating for the two user chains.
module bscan_virtex_sim
  import bscan_virtex_sim_pkg::*;
#(
  parameter int                  IR_WIDTH   = 5,
  parameter logic [IR_WIDTH-1:0] USER1_CODE = 5'h02,
  parameter logic [IR_WIDTH-1:0] USER2_CODE = 5'h03
) (
  input  logic TCK,
  input  logic TRST,
  input  logic TMS,
  input  logic TDI,
  input  logic TDO1,
  input  logic TDO2,
  output logic TDO,
  output logic BTDI,
  output logic SEL1,
  output logic SEL2,
  output logic DRCK1,
  output logic DRCK2,
  output logic SHIFT,
  output logic UPDATE,
  output logic RESET
);

  localparam logic [IR_WIDTH-1:0] IR_BYPASS  = IR_BYPASS_ALL[IR_WIDTH-1:0];
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_CAPTURE_ALL[IR_WIDTH-1:0];

  tap_state_t          state;
  logic [IR_WIDTH-1:0] ir_shift;
  logic [IR_WIDTH-1:0] ir;
  logic                bypass;
  logic                tdo_next;

  bscan_tap_fsm u_fsm (
    .tck              (TCK),
    .trst             (TRST),
    .tms              (TMS),
    .state            (state),
    .shift_dr         (SHIFT),
    .update_dr        (UPDATE),
    .test_logic_reset (RESET)
  );

  // IR and bypass shift registers move on rising TCK; TDI enters at the MSB.
  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      ir_shift <= IR_CAPTURE;
      bypass   <= 1'b0;
    end else begin
      if (state == CAPTURE_IR) begin
        ir_shift <= IR_CAPTURE;
      end else if (state == SHIFT_IR) begin
        ir_shift <= {TDI, ir_shift[IR_WIDTH-1:1]};
      end
      if (state == CAPTURE_DR) begin
        bypass <= 1'b0;
      end else if (state == SHIFT_DR) begin
        bypass <= TDI;
      end
    end
  end

  // The instruction takes effect on the falling edge so it is stable for the next rise.
  always_ff @(negedge TCK or posedge TRST) begin
    if (TRST) begin
      ir <= IR_BYPASS;
    end else if (state == TEST_LOGIC_RESET) begin
      ir <= IR_BYPASS;
    end else if (state == UPDATE_IR) begin
      ir <= ir_shift;
    end
  end

  assign SEL1 = (ir == USER1_CODE);
  assign SEL2 = (ir == USER2_CODE);
  assign BTDI = TDI;

  always_comb begin
    tdo_next = 1'b0;
    if (state == SHIFT_IR) begin
      tdo_next = ir_shift[0];
    end else if (state == SHIFT_DR) begin
      if (SEL1) begin
        tdo_next = TDO1;
      end else if (SEL2) begin
        tdo_next = TDO2;
      end else begin
        tdo_next = bypass;
      end
    end
  end

  always_ff @(negedge TCK or posedge TRST) begin
    if (TRST) begin
      TDO <= 1'b0;
    end else begin
      TDO <= tdo_next;
    end
  end

  // Gating only opens while TCK is high at a state change, so the pulse is never cut short.
  assign DRCK1 = (SEL1 && drck_window(state)) ? TCK : 1'b1;
  assign DRCK2 = (SEL2 && drck_window(state)) ? TCK : 1'b1;

endmodule

// File: tb/tb_bscan_virtex_sim.sv
// Self-checking bench for bscan_virtex_sim: randomized scans compared against a
// table-driven TAP model and scan-level expectations for IR, bypass and user chains.
module tb_bscan_virtex_sim;
  import bscan_virtex_sim_pkg::*;

  localparam int         W     = 5;
  localparam logic [4:0] USER1 = 5'h02;
  localparam logic [4:0] USER2 = 5'h03;
  localparam int         MAXN  = 300;

  // Model state numbering: TLR RTI SelDR CapDR ShDR Ex1DR PauDR Ex2DR UpdDR SelIR CapIR ShIR Ex1IR PauIR Ex2IR UpdIR
  localparam int S_TLR = 0;
  localparam int S_SHDR = 4;
  localparam int S_UPDDR = 8;
  localparam int S_SHIR = 11;
  int nxt0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int nxt1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

  logic TCK = 1'b0;
  logic TRST = 1'b0;
  logic TMS = 1'b1;
  logic TDI = 1'b0;
  logic TDO1 = 1'b0;
  logic TDO2 = 1'b0;
  logic TDO, BTDI, SEL1, SEL2, DRCK1, DRCK2, SHIFT, UPDATE, RESET;

  int passed = 0;
  int total = 0;

  int         m_state = 0;
  logic [4:0] m_ir = 5'h1F;
  logic       obs_tdo;
  int         shift_seen = 0;
  int         update_seen = 0;
  int         drck1_falls = 0;
  int         drck2_falls = 0;

  logic dr_tdi [MAXN];
  logic dr_t1  [MAXN];
  logic dr_t2  [MAXN];

  bscan_virtex_sim #(
    .IR_WIDTH   (W),
    .USER1_CODE (USER1),
    .USER2_CODE (USER2)
  ) dut (
    .TCK    (TCK),
    .TRST   (TRST),
    .TMS    (TMS),
    .TDI    (TDI),
    .TDO1   (TDO1),
    .TDO2   (TDO2),
    .TDO    (TDO),
    .BTDI   (BTDI),
    .SEL1   (SEL1),
    .SEL2   (SEL2),
    .DRCK1  (DRCK1),
    .DRCK2  (DRCK2),
    .SHIFT  (SHIFT),
    .UPDATE (UPDATE),
    .RESET  (RESET)
  );

  always #10 TCK = ~TCK;

  always @(negedge DRCK1) drck1_falls++;
  always @(negedge DRCK2) drck2_falls++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One TCK period: drive inputs, observe at falling edge + 1, return at rising edge + 2.
  task automatic step(input logic tms, input logic tdi, input logic t1, input logic t2);
    logic [3:0] exp_f, obs_f;
    TMS = tms; TDI = tdi; TDO1 = t1; TDO2 = t2;
    if (TRST) m_state = S_TLR;
    @(negedge TCK); #1;
    obs_tdo = TDO;
    obs_f = {RESET, SHIFT, UPDATE, BTDI};
    exp_f = {m_state == S_TLR, m_state == S_SHDR, m_state == S_UPDDR, tdi};
    total++;
    if (obs_f !== exp_f) $display("FAIL tap_flags{RESET,SHIFT,UPDATE,BTDI}: got %b expected %b (model state %0d)", obs_f, exp_f, m_state);
    else passed++;
    if (m_state != S_SHDR && m_state != S_SHIR) begin
      total++;
      if (TDO !== 1'b0) $display("FAIL tdo_idle: got %b expected 0 (model state %0d)", TDO, m_state);
      else passed++;
    end
    shift_seen += int'(SHIFT);
    update_seen += int'(UPDATE);
    @(posedge TCK); #2;
    m_state = TRST ? S_TLR : (tms ? nxt1[m_state] : nxt0[m_state]);
  endtask

  // IR scan from Run-Test/Idle; pause_at>0 detours through Pause-IR after that many bits.
  task automatic scan_ir(input logic [4:0] code, input int pause_at);
    logic [4:0] tdo_v, exp_v;
    step(1, 0, 0, 0); step(1, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
    for (int i = 0; i < W; i++) begin
      step((i == W-1) || (i == pause_at-1), code[i], 0, 0);
      tdo_v[i] = obs_tdo;
      if (i == pause_at-1 && i != W-1) begin
        step(0, 0, 0, 0); step(0, 0, 0, 0); step(1, 0, 0, 0); step(0, 0, 0, 0);
      end
    end
    step(1, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
    m_ir = code;
    exp_v = '0;
    exp_v[0] = 1'b1;
    total++;
    if (tdo_v !== exp_v) $display("FAIL ir_capture_tdo(code %h): got %b expected %b (LSB first out)", code, tdo_v, exp_v);
    else passed++;
    total++;
    if ({SEL1, SEL2} !== {code == USER1, code == USER2})
      $display("FAIL ir_select(code %h): got SEL1/SEL2=%b%b expected %b%b", code, SEL1, SEL2, code == USER1, code == USER2);
    else passed++;
  endtask

  // DR scan of n bits from dr_* arrays; expected TDO follows the active instruction.
  task automatic scan_dr(input int n, input int pause_at, input string name);
    logic sel1_m, sel2_m, exp_bit;
    int d1, d2, sh, up;
    sel1_m = (m_ir == USER1);
    sel2_m = (m_ir == USER2);
    d1 = drck1_falls; d2 = drck2_falls; sh = shift_seen; up = update_seen;
    step(0, 0, 0, 0); step(1, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
    for (int i = 0; i < n; i++) begin
      step((i == n-1) || (i == pause_at-1), dr_tdi[i], dr_t1[i], dr_t2[i]);
      if (sel1_m) exp_bit = dr_t1[i];
      else if (sel2_m) exp_bit = dr_t2[i];
      else exp_bit = (i == 0) ? 1'b0 : dr_tdi[i-1];
      total++;
      if (obs_tdo !== exp_bit) $display("FAIL %s tdo bit %0d: got %b expected %b", name, i, obs_tdo, exp_bit);
      else passed++;
      if (i == pause_at-1 && i != n-1) begin
        step(0, 0, 0, 0); step(0, 0, 0, 0); step(1, 0, 0, 0); step(0, 0, 0, 0);
      end
    end
    step(1, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
    d1 = drck1_falls - d1; d2 = drck2_falls - d2; sh = shift_seen - sh; up = update_seen - up;
    total++;
    if (d1 !== (sel1_m ? n + 1 : 0)) $display("FAIL %s drck1_pulses: got %0d expected %0d", name, d1, sel1_m ? n + 1 : 0);
    else passed++;
    total++;
    if (d2 !== (sel2_m ? n + 1 : 0)) $display("FAIL %s drck2_pulses: got %0d expected %0d", name, d2, sel2_m ? n + 1 : 0);
    else passed++;
    total++;
    if (sh !== n) $display("FAIL %s shift_cycles: got %0d expected %0d", name, sh, n);
    else passed++;
    total++;
    if (up !== 1) $display("FAIL %s update_cycles: got %0d expected 1", name, up);
    else passed++;
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) begin
      dr_tdi[i] = 1'($urandom & 1);
      dr_t1[i]  = 1'($urandom & 1);
      dr_t2[i]  = 1'($urandom & 1);
    end
  endtask

  task automatic test_reset();
    logic [7:0] pulse_v;
    TRST = 1'b1;
    for (int i = 0; i < 6; i++) step(1, 1'($urandom & 1), 0, 0);
    pulse_v = {RESET, SHIFT, UPDATE, TDO, SEL1, SEL2, DRCK1, DRCK2};
    total++;
    if (pulse_v !== 8'b1000_0011) $display("FAIL reset_outputs{RESET,SHIFT,UPDATE,TDO,SEL1,SEL2,DRCK1,DRCK2}: got %b expected 10000011", pulse_v);
    else passed++;
    TRST = 1'b0;
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    total++;
    if (dut.state !== RUN_TEST_IDLE) $display("FAIL reset_end_state: got %0d expected %0d", dut.state, RUN_TEST_IDLE);
    else passed++;
    total++;
    if ({SEL1, SEL2} !== 2'b00) $display("FAIL reset_sel: got %b%b expected 00", SEL1, SEL2);
    else passed++;
  endtask

  task automatic test_ir_user1();
    scan_ir(USER1, 0);
  endtask

  task automatic test_user2_dr();
    logic [7:0] data;
    data = 8'h05;
    scan_ir(USER2, 0);
    fill_random(8);
    for (int i = 0; i < 8; i++) dr_tdi[i] = data[i];
    scan_dr(8, 0, "user2_dr8");
  endtask

  task automatic test_long_dr();
    fill_random(288);
    scan_dr(288, 0, "user2_dr288");
  endtask

  task automatic test_bypass();
    logic [3:0] data;
    data = 4'b1011;
    scan_ir(5'h1F, 0);
    fill_random(4);
    for (int i = 0; i < 4; i++) dr_tdi[i] = data[i];
    scan_dr(4, 0, "bypass_dr4");
  endtask

  task automatic test_pause();
    scan_ir(USER1, 2);
    fill_random(12);
    scan_dr(12, 1 + int'($urandom_range(0, 9)), "user1_pause");
    scan_ir(5'h0A, 3);
    fill_random(10);
    scan_dr(10, 4, "bypass_pause");
  endtask

  task automatic test_random_scans();
    logic [4:0] code;
    int n;
    for (int k = 0; k < 8; k++) begin
      case ($urandom_range(0, 2))
        0: code = USER1;
        1: code = USER2;
        default: begin
          do code = 5'($urandom); while (code == USER1 || code == USER2);
        end
      endcase
      scan_ir(code, int'($urandom_range(0, 4)));
      n = int'($urandom_range(1, 24));
      fill_random(n);
      scan_dr(n, int'($urandom_range(0, 24)), "random_dr");
    end
  endtask

  task automatic test_random_walk();
    for (int i = 0; i < 200; i++)
      step(1'($urandom & 1), 1'($urandom & 1), 1'($urandom & 1), 1'($urandom & 1));
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
    total++;
    if (RESET !== 1'b1) $display("FAIL five_tms_reset: got RESET=%b expected 1", RESET);
    else passed++;
    step(1, 0, 0, 0);
    m_ir = 5'h1F;
    total++;
    if ({SEL1, SEL2} !== 2'b00) $display("FAIL walk_reset_sel: got %b%b expected 00", SEL1, SEL2);
    else passed++;
    step(0, 0, 0, 0);
  endtask

  task automatic test_trst_mid_shift();
    logic [7:0] v;
    scan_ir(USER1, 0);
    step(0, 0, 0, 0); step(1, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1'($urandom & 1), 1, 1);
    @(negedge TCK); #3;
    total++;
    if (DRCK1 !== 1'b0) $display("FAIL drck1_low_in_shift: got %b expected 0", DRCK1);
    else passed++;
    TRST = 1'b1;
    #1;
    v = {RESET, SHIFT, UPDATE, TDO, SEL1, SEL2, DRCK1, DRCK2};
    total++;
    if (v !== 8'b1000_0011) $display("FAIL trst_mid_shift{RESET,SHIFT,UPDATE,TDO,SEL1,SEL2,DRCK1,DRCK2}: got %b expected 10000011", v);
    else passed++;
    m_state = S_TLR;
    m_ir = 5'h1F;
    @(posedge TCK); #2;
    step(1, 0, 0, 0); step(1, 0, 0, 0);
    TRST = 1'b0;
    step(0, 0, 0, 0);
    scan_ir(USER2, 0);
    fill_random(6);
    scan_dr(6, 0, "after_trst_dr");
  endtask

  initial begin
    #1 TRST = 1'b1;
    @(posedge TCK); #2;
    m_state = S_TLR;
    test_reset();
    test_ir_user1();
    test_user2_dr();
    test_long_dr();
    test_bypass();
    test_pause();
    test_random_scans();
    test_random_walk();
    test_trst_mid_shift();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bscan_virtex_sim.md
BSCAN_VIRTEX_SIM -- requirements
Module: bscan_virtex_sim

Interface
REQ-001 Parameter IR_WIDTH, default 5: instruction register width in bits.
REQ-002 Parameter USER1_CODE, default 5'h02: instruction that selects USER1.
REQ-003 Parameter USER2_CODE, default 5'h03: instruction that selects USER2.
REQ-004 Port TCK, input, 1 bit: the single clock (test clock).
REQ-005 Port TRST, input, 1 bit: reset, asynchronous and active-high; forces Test-Logic-Reset.
REQ-006 Port TMS, input, 1 bit: TAP mode select, sampled on rising TCK.
REQ-007 Port TDI, input, 1 bit: serial data into the TAP.
REQ-008 Port TDO1, input, 1 bit: serial return data from the USER1 user chain.
REQ-009 Port TDO2, input, 1 bit: serial return data from the USER2 user chain.
REQ-010 Port TDO, output, 1 bit: serial data out of the TAP.
REQ-011 Port BTDI, output, 1 bit: TDI buffered to the user logic.
REQ-012 Ports SEL1 and SEL2, outputs, 1 bit each: USER1 / USER2 instruction active.
REQ-013 Ports DRCK1 and DRCK2, outputs, 1 bit each: gated data-register clocks for USER1 / USER2.
REQ-014 Port SHIFT, output, 1 bit: TAP is in Shift-DR.
REQ-015 Port UPDATE, output, 1 bit: TAP is in Update-DR.
REQ-016 Port RESET, output, 1 bit: TAP is in Test-Logic-Reset.

Function
REQ-017 The TAP controller SHALL implement the 16-state IEEE 1149.1 FSM, with transitions on rising TCK as a function of TMS.
REQ-018 Five consecutive TMS=1 clocks SHALL reach Test-Logic-Reset from any state.
REQ-019 In Capture-IR the instruction shift register SHALL load {IR_WIDTH-2 zeros, 2'b01}.
REQ-020 In Shift-IR the instruction shift register SHALL shift LSB-first on rising TCK, with TDI entering at the MSB.
REQ-021 The instruction register SHALL load from the shift register on falling TCK while in Update-IR.
REQ-022 In Test-Logic-Reset the instruction register SHALL be all ones (BYPASS).
REQ-023 SEL1 SHALL equal (IR==USER1_CODE); SEL2 SHALL equal (IR==USER2_CODE).
REQ-024 DRCK1 SHALL follow TCK while SEL1 is high and the state is Capture-DR or Shift-DR, and SHALL be held at 1 otherwise; DRCK2 SHALL behave the same with SEL2.
REQ-025 SHIFT, UPDATE and RESET SHALL be decodes of the registered state and SHALL be glitch-free.
REQ-026 BTDI SHALL be combinationally equal to TDI.
REQ-027 A 1-bit bypass register SHALL capture 0 in Capture-DR and take TDI on rising TCK in Shift-DR.
REQ-028 The TDO source SHALL be selected as follows:
- Shift-IR: instruction shift register bit 0.
- Shift-DR with SEL1: TDO1.
- Shift-DR with SEL2: TDO2.
- Shift-DR with any other instruction: bypass register.
REQ-029 TDO SHALL be registered on falling TCK and SHALL be driven 0 outside Shift-IR and Shift-DR.
REQ-030 An Exit1/Pause round trip SHALL preserve the shift-register contents.

Reset
REQ-031 Asserting TRST SHALL immediately force the following, independent of TCK:
- state = Test-Logic-Reset;
- IR = all ones;
- TDO = 0;
- RESET = 1;
- SEL1 = SEL2 = SHIFT = UPDATE = 0;
- DRCK1 = DRCK2 = 1.
REQ-032 Asserting TRST in the middle of a scan SHALL abort the scan and SHALL leave the IR unchanged apart from the BYPASS reset value.

Structure
REQ-033 A shared package SHALL hold the TAP state enumeration and the BYPASS / capture-IR constants.
REQ-034 The TAP FSM SHALL be a sub-module named bscan_tap_fsm.
REQ-035 The IR, bypass, TDO multiplexer and DRCK gating SHALL live in the top level.
REQ-036 The block is simulation-only and SHALL contain no vendor primitives.

Verification
REQ-037 TRST pulse 6 TCK-equivalents, then TMS=1,1,1,1,1,1,0,0 -> RESET=1 during the pulse; FSM ends in Run-Test/Idle; SEL1=SEL2=0.
REQ-038 IR scan 5'd2: header TMS 1,1,0,0; shift with TMS=1 on the last bit; trailer 1,0,0 -> SEL1=1, SEL2=0; TDO during the shift shows 1,0,0,0,0.
REQ-039 USER2 selected, DR scan of 8 bits 8'h05: header TMS 0,1,0,0 -> 9 DRCK2 pulses (Capture plus 8 Shift); DRCK1 stays 1; SHIFT high for 8 clocks; UPDATE high for one TCK; TDO equals the TDO2 stimulus delayed by half a TCK.
REQ-040 USER2 selected, 288-bit DR scan -> exactly 289 DRCK2 falling edges; BTDI equals TDI throughout.
REQ-041 IR = 5'h1F, 4-bit DR scan 4'b1011 -> TDO bits are 0,1,1,0 (the bypass delay of one clock); SEL1=SEL2=0; DRCK1=DRCK2=1.
REQ-042 TRST asserted mid Shift-DR -> outputs take the REQ-031 values immediately; the next IR scan works normally.
